// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin grant, fixed-length access with
// configurable wait states, one-cycle DTAck pulse, one-cycle recovery.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate any request sampled on the next edge
// ACCESS  | granted master mirrored onto the bus for WAIT_CYCLES+1 cycles
// ACK     | granted master's DTAck high, read data valid
// RECOVER | Grant 00, all requests ignored for one cycle
module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        M0_AS_L,
  input  logic        M1_AS_L,
  input  logic        M0_WE_L,
  input  logic        M1_WE_L,
  input  logic [31:0] M0_Address,
  input  logic [31:0] M1_Address,
  input  logic [3:0]  M0_ByteEnable,
  input  logic [3:0]  M1_ByteEnable,
  input  logic [31:0] M0_DataOut,
  input  logic [31:0] M1_DataOut,
  output logic        M0_DTAck,
  output logic        M1_DTAck,
  output logic [31:0] M0_ReadData,
  output logic [31:0] M1_ReadData,
  output logic        Bus_AS_L,
  output logic        Bus_WE_L,
  output logic [31:0] Bus_Address,
  output logic [3:0]  Bus_ByteEnable,
  output logic [31:0] Bus_DataOut,
  input  logic [31:0] Bus_ReadData,
  output logic [1:0]  Grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RECOVER} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  dtack_q, dtack_d;
  logic        last_m1_q, last_m1_d;  // 1: M1 was granted most recently
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;
  logic        req0, req1, pick_m1;

  assign req0 = ~M0_AS_L;
  assign req1 = ~M1_AS_L;
  // On a tie the master not granted last wins.
  assign pick_m1 = req1 & (~req0 | ~last_m1_q);

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      dtack_q   <= '0;
      last_m1_q <= 1'b1;
      rd0_q     <= '0;
      rd1_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      dtack_q   <= dtack_d;
      last_m1_q <= last_m1_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
    end
  end

  // Next-state logic: arbitration, wait-state down-counter, read capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    dtack_d   = '0;
    last_m1_d = last_m1_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (req0 || req1) begin
          state_d   = ACCESS;
          grant_d   = pick_m1 ? 2'b10 : 2'b01;
          last_m1_d = pick_m1;
          cnt_d     = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          dtack_d = grant_q;
          if (grant_q[0]) rd0_d = Bus_ReadData;
          if (grant_q[1]) rd1_d = Bus_ReadData;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = RECOVER;
        grant_d = '0;
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Bus mux: granted master drives the bus only while in ACCESS.
  always_comb begin
    Bus_AS_L       = 1'b1;
    Bus_WE_L       = 1'b1;
    Bus_Address    = '0;
    Bus_ByteEnable = '0;
    Bus_DataOut    = '0;
    if (state_q == ACCESS) begin
      Bus_AS_L = 1'b0;
      if (grant_q[1]) begin
        Bus_WE_L       = M1_WE_L;
        Bus_Address    = M1_Address;
        Bus_ByteEnable = M1_ByteEnable;
        Bus_DataOut    = M1_DataOut;
      end else begin
        Bus_WE_L       = M0_WE_L;
        Bus_Address    = M0_Address;
        Bus_ByteEnable = M0_ByteEnable;
        Bus_DataOut    = M0_DataOut;
      end
    end
  end

  assign M0_DTAck    = dtack_q[0];
  assign M1_DTAck    = dtack_q[1];
  assign M0_ReadData = rd0_q;
  assign M1_ReadData = rd1_q;
  assign Grant       = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one WAIT_CYCLES=1 instance for the main
// scenarios, one WAIT_CYCLES=0 instance for the zero-wait case.
module tb_bus_arbiter;

  localparam int W = 1;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic        M0_AS_L, M1_AS_L, M0_WE_L, M1_WE_L;
  logic [31:0] M0_Address, M1_Address, M0_DataOut, M1_DataOut;
  logic [3:0]  M0_ByteEnable, M1_ByteEnable;
  logic [31:0] Bus_ReadData;

  logic        M0_DTAck, M1_DTAck, Bus_AS_L, Bus_WE_L;
  logic [31:0] M0_ReadData, M1_ReadData, Bus_Address, Bus_DataOut;
  logic [3:0]  Bus_ByteEnable;
  logic [1:0]  Grant;

  logic        w0_M0_DTAck, w0_M1_DTAck, w0_Bus_AS_L, w0_Bus_WE_L;
  logic [31:0] w0_M0_ReadData, w0_M1_ReadData, w0_Bus_Address, w0_Bus_DataOut;
  logic [3:0]  w0_Bus_ByteEnable;
  logic [1:0]  w0_Grant;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  bus_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .M0_AS_L(M0_AS_L), .M1_AS_L(M1_AS_L), .M0_WE_L(M0_WE_L), .M1_WE_L(M1_WE_L),
    .M0_Address(M0_Address), .M1_Address(M1_Address),
    .M0_ByteEnable(M0_ByteEnable), .M1_ByteEnable(M1_ByteEnable),
    .M0_DataOut(M0_DataOut), .M1_DataOut(M1_DataOut),
    .M0_DTAck(M0_DTAck), .M1_DTAck(M1_DTAck),
    .M0_ReadData(M0_ReadData), .M1_ReadData(M1_ReadData),
    .Bus_AS_L(Bus_AS_L), .Bus_WE_L(Bus_WE_L), .Bus_Address(Bus_Address),
    .Bus_ByteEnable(Bus_ByteEnable), .Bus_DataOut(Bus_DataOut),
    .Bus_ReadData(Bus_ReadData), .Grant(Grant)
  );

  bus_arbiter #(.WAIT_CYCLES(0)) u_dut_w0 (
    .Clock(Clock), .Reset_L(Reset_L),
    .M0_AS_L(M0_AS_L), .M1_AS_L(M1_AS_L), .M0_WE_L(M0_WE_L), .M1_WE_L(M1_WE_L),
    .M0_Address(M0_Address), .M1_Address(M1_Address),
    .M0_ByteEnable(M0_ByteEnable), .M1_ByteEnable(M1_ByteEnable),
    .M0_DataOut(M0_DataOut), .M1_DataOut(M1_DataOut),
    .M0_DTAck(w0_M0_DTAck), .M1_DTAck(w0_M1_DTAck),
    .M0_ReadData(w0_M0_ReadData), .M1_ReadData(w0_M1_ReadData),
    .Bus_AS_L(w0_Bus_AS_L), .Bus_WE_L(w0_Bus_WE_L), .Bus_Address(w0_Bus_Address),
    .Bus_ByteEnable(w0_Bus_ByteEnable), .Bus_DataOut(w0_Bus_DataOut),
    .Bus_ReadData(Bus_ReadData), .Grant(w0_Grant)
  );

  typedef struct {
    logic [1:0]  who;      // 01 = M0 requests, 10 = M1 requests
    logic        we_l;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;    // value presented on Bus_ReadData
    logic [31:0] exp_rd0;  // M0_ReadData expected after the access
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Both masters idle; non-granted fields carry distinct junk so a wrong
  // mux select is visible on the bus.
  task automatic idle_masters();
    M0_AS_L = 1'b1; M0_WE_L = 1'b1; M0_Address = 32'h4444_0000;
    M0_ByteEnable = 4'b0101; M0_DataOut = 32'h6666_6666;
    M1_AS_L = 1'b1; M1_WE_L = 1'b0; M1_Address = 32'h5555_0000;
    M1_ByteEnable = 4'b1010; M1_DataOut = 32'h7777_7777;
  endtask

  task automatic do_reset();
    idle_masters();
    Reset_L = 1'b0;
    step();
    step();
    Reset_L = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    if (v.who == 2'b01) begin
      M0_AS_L = 1'b0; M0_WE_L = v.we_l; M0_Address = v.addr;
      M0_ByteEnable = v.be; M0_DataOut = v.wdata;
    end else begin
      M1_AS_L = 1'b0; M1_WE_L = v.we_l; M1_Address = v.addr;
      M1_ByteEnable = v.be; M1_DataOut = v.wdata;
    end
    Bus_ReadData = v.rdata;
    step();
    for (int i = 0; i <= W; i++) begin
      chk($sformatf("v%0d_c%0d_as", idx, i), 32'(Bus_AS_L), 32'd0);
      chk($sformatf("v%0d_c%0d_we", idx, i), 32'(Bus_WE_L), 32'(v.we_l));
      chk($sformatf("v%0d_c%0d_addr", idx, i), Bus_Address, v.addr);
      chk($sformatf("v%0d_c%0d_be", idx, i), 32'(Bus_ByteEnable), 32'(v.be));
      chk($sformatf("v%0d_c%0d_dout", idx, i), Bus_DataOut, v.wdata);
      chk($sformatf("v%0d_c%0d_grant", idx, i), 32'(Grant), 32'(v.who));
      chk($sformatf("v%0d_c%0d_dtack", idx, i), 32'({M1_DTAck, M0_DTAck}), 32'd0);
      step();
    end
    chk($sformatf("v%0d_ack_dtack", idx), 32'({M1_DTAck, M0_DTAck}), 32'(v.who));
    chk($sformatf("v%0d_ack_grant", idx), 32'(Grant), 32'(v.who));
    chk($sformatf("v%0d_ack_bus_idle", idx), {31'd0, Bus_AS_L} | Bus_Address, 32'd1);
    chk($sformatf("v%0d_rd0", idx), M0_ReadData, v.exp_rd0);
    chk($sformatf("v%0d_rd1", idx), M1_ReadData, v.exp_rd1);
    idle_masters();
    step();
    chk($sformatf("v%0d_rec_grant", idx), 32'(Grant), 32'd0);
    chk($sformatf("v%0d_rec_dtack", idx), 32'({M1_DTAck, M0_DTAck}), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, n, bad, prev_t;
    logic [1:0] prev_ack;
    logic [1:0] order[6];
    int times[6];

    vecs[0] = '{2'b01, 1'b1, 32'h0000_0100, 4'hF,    32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{2'b10, 1'b0, 32'h0800_0000, 4'b0011, 32'h1234_5678, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hA5A5_A5A5};
    vecs[2] = '{2'b10, 1'b1, 32'h2000_0004, 4'hF,    32'h0,         32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    vecs[3] = '{2'b01, 1'b0, 32'hFFFF_FFFC, 4'b1000, 32'hCAFE_F00D, 32'h1111_2222, 32'h1111_2222, 32'h0BAD_F00D};

    // Reset values, with a request pending to show it has no effect.
    idle_masters();
    Bus_ReadData = 32'h9999_9999;
    Reset_L = 1'b0;
    M0_AS_L = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_dtack", 32'({M1_DTAck, M0_DTAck}), 32'd0);
    chk("rst_rd0", M0_ReadData, 32'd0);
    chk("rst_rd1", M1_ReadData, 32'd0);
    chk("rst_bus_ctl", 32'({Bus_AS_L, Bus_WE_L}), 32'd3);
    chk("rst_bus_addr", Bus_Address, 32'd0);
    chk("rst_bus_be", 32'(Bus_ByteEnable), 32'd0);
    chk("rst_bus_dout", Bus_DataOut, 32'd0);
    chk("rst_w0_grant", 32'(w0_Grant), 32'd0);
    idle_masters();
    Reset_L = 1'b1;
    step();

    for (int k = 0; k < 4; k++) run_vec(k, vecs[k]);

    // Simultaneous requests after reset: M0 first, M1 five cycles later.
    do_reset();
    M0_AS_L = 1'b0; M0_Address = 32'h0000_0200;
    M1_AS_L = 1'b0; M1_Address = 32'h0000_0300;
    Bus_ReadData = 32'h3333_4444;
    t0 = -1; t1 = -1; bad = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (cyc == 1) chk("tie_grant_first", 32'(Grant), 32'd1);
      if (cyc == 4) chk("tie_recover_grant", 32'(Grant), 32'd0);
      if (cyc == 6) chk("tie_grant_second", 32'(Grant), 32'd2);
      if (M0_DTAck && M1_DTAck) bad++;
      if (M1_DTAck && t0 < 0) bad++;
      if (M0_DTAck) begin t0 = cyc; M0_AS_L = 1'b1; end
      if (M1_DTAck) begin t1 = cyc; M1_AS_L = 1'b1; end
    end
    chk("tie_m0_dtack_cycle", 32'(t0), 32'd3);
    chk("tie_m1_dtack_gap", 32'(t1 - t0), 32'd5);
    chk("tie_no_overlap", 32'(bad), 32'd0);

    // Continuous requests from both: strict alternation, no overlap.
    do_reset();
    M0_AS_L = 1'b0;
    M1_AS_L = 1'b0;
    n = 0; bad = 0; prev_ack = 2'b00;
    for (int k = 0; k < 6; k++) begin order[k] = 2'b00; times[k] = 0; end
    for (int cyc = 1; cyc <= 40 && n < 6; cyc++) begin
      step();
      if (M0_DTAck && M1_DTAck) bad++;
      if ((prev_ack & {M1_DTAck, M0_DTAck}) != 2'b00) bad++;
      prev_ack = {M1_DTAck, M0_DTAck};
      if (M0_DTAck || M1_DTAck) begin
        order[n] = {M1_DTAck, M0_DTAck};
        times[n] = cyc;
        n++;
      end
    end
    chk("rr_count", 32'(n), 32'd6);
    chk("rr_bad", 32'(bad), 32'd0);
    prev_t = times[0];
    chk("rr_first_time", 32'(prev_t), 32'd3);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_order%0d", k), 32'(order[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(times[k] - times[k-1]), 32'd5);
    end
    idle_masters();

    // Granted master drops AS_L mid-access: access still completes.
    do_reset();
    M0_AS_L = 1'b0; M0_WE_L = 1'b1; M0_Address = 32'h0000_0300;
    Bus_ReadData = 32'h600D_F00D;
    step();
    chk("drop_c0_as", 32'(Bus_AS_L), 32'd0);
    M0_AS_L = 1'b1;
    step();
    chk("drop_c1_as", 32'(Bus_AS_L), 32'd0);
    chk("drop_c1_addr", Bus_Address, 32'h0000_0300);
    step();
    chk("drop_dtack", 32'(M0_DTAck), 32'd1);
    chk("drop_rd0", M0_ReadData, 32'h600D_F00D);
    step();
    step();
    step();
    chk("drop_no_reaccess", 32'({Grant, Bus_AS_L}), 32'd1);

    // Reset during the second ACCESS cycle, then a fresh M1 access.
    do_reset();
    M0_AS_L = 1'b0; M0_Address = 32'h0000_0400;
    Bus_ReadData = 32'h2468_1357;
    step();
    step();
    chk("mid_rst_pre_as", 32'(Bus_AS_L), 32'd0);
    Reset_L = 1'b0;
    #1;
    chk("mid_rst_bus_as", 32'(Bus_AS_L), 32'd1);
    chk("mid_rst_bus_addr", Bus_Address, 32'd0);
    chk("mid_rst_grant", 32'(Grant), 32'd0);
    M0_AS_L = 1'b1;
    bad = 0;
    step();
    if (M0_DTAck || M1_DTAck) bad++;
    step();
    Reset_L = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step();
      if (M0_DTAck || M1_DTAck) bad++;
    end
    chk("mid_rst_no_dtack", 32'(bad), 32'd0);
    chk("mid_rst_rd0", M0_ReadData, 32'd0);
    M1_AS_L = 1'b0; M1_WE_L = 1'b1; M1_Address = 32'h0000_0500;
    Bus_ReadData = 32'h1357_2468;
    step();
    chk("post_rst_grant", 32'(Grant), 32'd2);
    step();
    step();
    chk("post_rst_dtack", 32'({M1_DTAck, M0_DTAck}), 32'd2);
    chk("post_rst_rd1", M1_ReadData, 32'h1357_2468);
    idle_masters();
    step();

    // Zero-wait instance: one ACCESS cycle, DTAck on the next.
    do_reset();
    M0_AS_L = 1'b0; M0_WE_L = 1'b1; M0_Address = 32'h0000_0100;
    Bus_ReadData = 32'hFEED_FACE;
    step();
    chk("w0_c0_as", 32'(w0_Bus_AS_L), 32'd0);
    chk("w0_c0_addr", w0_Bus_Address, 32'h0000_0100);
    chk("w0_c0_dtack", 32'(w0_M0_DTAck), 32'd0);
    step();
    chk("w0_ack_dtack", 32'(w0_M0_DTAck), 32'd1);
    chk("w0_ack_as", 32'(w0_Bus_AS_L), 32'd1);
    chk("w0_ack_rd0", w0_M0_ReadData, 32'hFEED_FACE);
    idle_masters();
    step();
    chk("w0_rec_dtack", 32'(w0_M0_DTAck), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: WAIT_CYCLES, default 1, number of extra cycles a bus access is held before completion (legal range 0-15).
REQ-002 The block SHALL have the port Clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port Reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the ports M0_AS_L / M1_AS_L, input, 1 bit each: master 0 (CPU) and master 1 (DMA/fill engine) request, active low.
REQ-005 The block SHALL have the ports M0_WE_L / M1_WE_L, input, 1 bit each: write strobe, active low.
REQ-006 The block SHALL have the ports M0_Address / M1_Address, input, 32 bits each: byte address.
REQ-007 The block SHALL have the ports M0_ByteEnable / M1_ByteEnable, input, 4 bits each: byte lanes.
REQ-008 The block SHALL have the ports M0_DataOut / M1_DataOut, input, 32 bits each: write data.
REQ-009 The block SHALL have the ports M0_DTAck / M1_DTAck, output, 1 bit each: one-cycle completion pulse, active high.
REQ-010 The block SHALL have the ports M0_ReadData / M1_ReadData, output, 32 bits each: registered read data, valid while the matching DTAck is high.
REQ-011 The block SHALL have the ports Bus_AS_L, Bus_WE_L (output, 1 bit each), Bus_Address (output, 32), Bus_ByteEnable (output, 4) and Bus_DataOut (output, 32): the shared slave-side bus.
REQ-012 The block SHALL have the port Bus_ReadData, input, 32 bits: output of the data-bus multiplexer.
REQ-013 The block SHALL have the port Grant, output, 2 bits: one-hot current owner (bit0 = M0, bit1 = M1).

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ACCESS, ACK and RECOVER.
REQ-015 In IDLE, when any Mx_AS_L is low at a rising edge, the block SHALL move to ACCESS and latch the winner into Grant.
REQ-016 When both masters request in the same IDLE cycle, the block SHALL grant the master not granted last (round-robin); the last-grant register resets to M1, so M0 wins the first tie.
REQ-017 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by a 4-bit counter, then move to ACK.
REQ-018 During ACCESS, the Bus_* outputs SHALL combinationally mirror the granted master's signals, with Bus_AS_L low.
REQ-019 Outside ACCESS, Bus_AS_L and Bus_WE_L SHALL be 1 and Bus_Address, Bus_ByteEnable and Bus_DataOut SHALL be 0.
REQ-020 At the edge leaving ACCESS, Bus_ReadData SHALL be registered into the granted master's ReadData; the other master's ReadData is held.
REQ-021 In ACK, the block SHALL assert the granted master's DTAck for exactly one cycle, keep Grant unchanged, and move to RECOVER.
REQ-022 In RECOVER, Grant SHALL be 00 and all requests SHALL be ignored for exactly one cycle, after which the block moves to IDLE; masters deassert AS_L in the cycle after DTAck.
REQ-023 Total latency from a request sampled in IDLE to DTAck high SHALL be WAIT_CYCLES+2 cycles.
REQ-024 Grant SHALL be 00 in IDLE and RECOVER.
REQ-025 If the granted master raises AS_L mid-ACCESS, the block SHALL complete the access unchanged, including the DTAck pulse; that master's signals are still mirrored.
REQ-026 A non-granted master's request SHALL be held pending, with no DTAck, until a later IDLE cycle in which it wins arbitration.
REQ-027 Each DTAck SHALL never be high in two consecutive cycles, and both DTAcks SHALL never be high together.

Reset
REQ-028 Asserting Reset_L low at any time, including mid-ACCESS, SHALL immediately force the state to IDLE, the counter to 0, Grant to 00, the last-grant register to M1, DTAcks to 0 and both ReadData outputs to 0.
REQ-029 While in reset, the bus outputs SHALL take their idle values (Bus_AS_L=1, Bus_WE_L=1, other bus outputs 0).
REQ-030 An access interrupted by reset SHALL never produce a DTAck.
REQ-031 After Reset_L is released, the first arbitration SHALL occur at the first rising edge with a request.

Verification
REQ-032 M0 read alone at 0x0000_0100, WAIT_CYCLES=1, Bus_ReadData=0xDEADBEEF -> Bus_AS_L low 2 cycles, M0_DTAck high in cycle 3, M0_ReadData=0xDEADBEEF.
REQ-033 M0 and M1 request in the same cycle after reset -> M0 served first, then RECOVER, then M1 served; M1_DTAck arrives exactly 5 cycles after M0_DTAck (WAIT_CYCLES=1).
REQ-034 Both masters request continuously for 6 transactions -> grants alternate M0, M1, M0, ...; no DTAck overlap.
REQ-035 M1 write 0x12345678, ByteEnable 0011, to 0x0800_0000 -> Bus_WE_L low and Bus_DataOut, Bus_ByteEnable and Bus_Address match for every ACCESS cycle; M1_DTAck pulses once.
REQ-036 Reset_L pulsed low during the second ACCESS cycle -> bus idles immediately, no DTAck, Grant=00; a new M1 request after release is served normally.
REQ-037 WAIT_CYCLES=0 build, single M0 read -> Bus_AS_L low 1 cycle, M0_DTAck 2 cycles after the request is sampled.
